// File: rtl/exmem_stage_reg_pkg.sv
// Shared constants for the EX/MEM stage register: FSM encoding, default widths, bubble values.
package exmem_stage_reg_pkg;

    localparam int unsigned EXMEM_DATA_W = 16;
    localparam int unsigned EXMEM_REG_W  = 3;
    localparam int unsigned INSTR_W      = 16;
    localparam int unsigned CNT_W        = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Bubble contents: an invalid slot with no side effects and cleared data.
    localparam logic               BUBBLE_VALID = 1'b0;
    localparam logic               BUBBLE_CTRL  = 1'b0;
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = '0;

endpackage

// File: rtl/exmem_mem_fsm.sv
// Data-memory access sequencer: IDLE/WAIT state, request/stall generation, timeout and sticky error.
module exmem_mem_fsm
    import exmem_stage_reg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_mem_op_i,
    input  logic mem_done_i,
    output logic mem_req_o,
    output logic stall_o,
    output logic mem_err_o
);

    localparam logic [CNT_W:0] TIMEOUT_X = (CNT_W+1)'(TIMEOUT);

    mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;

    // Any edge that loads the stage register decides whether a new access starts.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        if (state_q == ST_IDLE) begin
            state_d    = load_mem_op_i ? ST_WAIT : ST_IDLE;
            wait_cnt_d = '0;
        end else if (mem_done_i) begin
            state_d    = load_mem_op_i ? ST_WAIT : ST_IDLE;
            wait_cnt_d = '0;
        end else begin
            if ({1'b0, wait_cnt_q} < TIMEOUT_X) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            if (({1'b0, wait_cnt_q} + (CNT_W+1)'(1)) >= TIMEOUT_X) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign mem_req_o = (state_q == ST_WAIT);
    assign stall_o   = mem_req_o & ~mem_done_i;
    assign mem_err_o = err_q;

endmodule

// File: rtl/exmem_stage_reg.sv
// EX/MEM pipeline register with multi-cycle memory access sequencing.
// Optional stall-cycle performance counter enabled by EXMEM_PERF_CNT_EN.
module exmem_stage_reg
    import exmem_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W  = EXMEM_DATA_W,
    parameter int unsigned REG_W   = EXMEM_REG_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   ex_alu_out,
    input  logic [DATA_W-1:0]   ex_set,
    input  logic [INSTR_W-1:0]  ex_instr,
    input  logic [DATA_W-1:0]   ex_store_data,
    input  logic [REG_W-1:0]    ex_dst_reg,
    input  logic                ex_reg_write_en,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                ex_valid,
    input  logic                flush,
    input  logic                mem_done,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   exmem_alu_out,
    output logic [DATA_W-1:0]   exmem_set,
    output logic [DATA_W-1:0]   exmem_store_data,
    output logic [INSTR_W-1:0]  exmem_instr,
    output logic [REG_W-1:0]    exmem_dst_reg,
    output logic                exmem_reg_write_en,
    output logic                exmem_mem_read,
    output logic                exmem_mem_write,
    output logic                exmem_valid,
    output logic                mem_req,
    output logic [DATA_W-1:0]   wb_data,
    output logic                stall_out,
    output logic                mem_err,
    output logic [CNT_W-1:0]    stall_cycles
);

    logic [DATA_W-1:0]  alu_q, alu_d;
    logic [DATA_W-1:0]  set_q, set_d;
    logic [DATA_W-1:0]  sdata_q, sdata_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [REG_W-1:0]   dst_q, dst_d;
    logic               we_q, we_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               valid_q, valid_d;
    logic               load;
    logic               load_mem_op;

    assign load        = ~stall_out;
    assign load_mem_op = ex_valid & (ex_mem_read | ex_mem_write) & ~flush;

    always_comb begin
        alu_d   = alu_q;
        set_d   = set_q;
        sdata_d = sdata_q;
        instr_d = instr_q;
        dst_d   = dst_q;
        we_d    = we_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        valid_d = valid_q;
        if (load) begin
            if (flush) begin
                alu_d   = '0;
                set_d   = '0;
                sdata_d = '0;
                instr_d = BUBBLE_INSTR;
                dst_d   = '0;
                we_d    = BUBBLE_CTRL;
                rd_d    = BUBBLE_CTRL;
                wr_d    = BUBBLE_CTRL;
                valid_d = BUBBLE_VALID;
            end else begin
                alu_d   = ex_alu_out;
                set_d   = ex_set;
                sdata_d = ex_store_data;
                instr_d = ex_instr;
                dst_d   = ex_dst_reg;
                we_d    = ex_reg_write_en;
                rd_d    = ex_mem_read;
                wr_d    = ex_mem_write;
                valid_d = ex_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q   <= '0;
            set_q   <= '0;
            sdata_q <= '0;
            instr_q <= '0;
            dst_q   <= '0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            set_q   <= set_d;
            sdata_q <= sdata_d;
            instr_q <= instr_d;
            dst_q   <= dst_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
        end
    end

    exmem_mem_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_fsm (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_mem_op_i(load_mem_op),
        .mem_done_i   (mem_done),
        .mem_req_o    (mem_req),
        .stall_o      (stall_out),
        .mem_err_o    (mem_err)
    );

`ifdef EXMEM_PERF_CNT_EN
    logic [CNT_W-1:0] perf_q, perf_d;

    // Saturating count of stalled edges.
    always_comb begin
        perf_d = perf_q;
        if (stall_out && (perf_q != '1)) begin
            perf_d = perf_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = '0;
`endif

    assign exmem_alu_out      = alu_q;
    assign exmem_set          = set_q;
    assign exmem_store_data   = sdata_q;
    assign exmem_instr        = instr_q;
    assign exmem_dst_reg      = dst_q;
    assign exmem_reg_write_en = we_q;
    assign exmem_mem_read     = rd_q;
    assign exmem_mem_write    = wr_q;
    assign exmem_valid        = valid_q;
    assign wb_data            = rd_q ? mem_rdata : alu_q;

endmodule

// File: doc/exmem_stage_reg.md
Name: exmem_stage_reg

Overview:
- EX/MEM pipeline register directly downstream of the execute stage.
- Latches the ALU result, set value, instruction, store data and destination-register info produced by EX.
- Supplies the EX/MEM forwarding sources back to the execute stage's forward unit.
- Sequences multi-cycle data-memory accesses through a 2-state FSM, holding the upstream pipeline while an access is outstanding.

Parameters:
- DATA_W, 16, datapath width.
- REG_W, 3, register-number width.
- TIMEOUT, 255, WAIT-cycle limit before mem_err is raised; must be < 2^16.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_alu_out  in  DATA_W  ALU result from EX
- ex_set  in  DATA_W  conditional-set result from EX
- ex_instr  in  16  instruction in EX
- ex_store_data  in  DATA_W  forwarded Rt value, used as store data
- ex_dst_reg  in  REG_W  destination register number
- ex_reg_write_en  in  1  register write enable
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_valid  in  1  EX holds a real instruction
- flush  in  1  insert a bubble at the next load edge
- mem_done  in  1  data memory completes the current access this cycle
- mem_rdata  in  DATA_W  load data, valid with mem_done
- exmem_alu_out, exmem_set, exmem_store_data  out  DATA_W  registered copies
- exmem_instr  out  16  registered copy
- exmem_dst_reg  out  REG_W  registered copy
- exmem_reg_write_en, exmem_mem_read, exmem_mem_write, exmem_valid  out  1  registered copies (effective value is gated by exmem_valid)
- mem_req  out  1  level access request; addr = exmem_alu_out, wdata = exmem_store_data
- wb_data  out  DATA_W  exmem_mem_read ? mem_rdata : exmem_alu_out (combinational)
- stall_out  out  1  freeze IF/ID/EX
- mem_err  out  1  sticky timeout flag
- stall_cycles  out  16  performance counter (see Optional Feature)

Behaviour:
- Reset: every registered output = 0, FSM = IDLE, wait counter = 0, mem_err = 0. Takes effect asynchronously.
- Reset during WAIT abandons the access; mem_req drops immediately.
- Load enable: load = ~stall_out.
  - On a rising edge with load=1 and flush=1: capture a bubble. valid, reg_write_en, mem_read and mem_write = 0; data fields = 0.
  - Load=1, flush=0: capture all ex_* inputs. valid = ex_valid.
  - Load=0: hold all fields. A flush asserted while load=0 is ignored; upstream holds flush with its stall.
- mem_op = exmem_valid & (exmem_mem_read | exmem_mem_write).
- FSM IDLE:
  - mem_req=0, stall_out=0.
  - Next state is WAIT if the captured instruction is a valid mem op (ex_valid & (ex_mem_read|ex_mem_write) & ~flush); otherwise IDLE.
  - mem_done in IDLE is ignored.
- FSM WAIT:
  - mem_req=1, stall_out=~mem_done (combinational path from mem_done).
  - On mem_done=1: load occurs on that edge; wb_data carries mem_rdata for a load. Next state is WAIT if the newly captured instruction is a mem op (back-to-back), else IDLE.
  - Flush arriving during WAIT never aborts an in-flight access; stores always complete.
- Timeout counter:
  - Cleared on entry to WAIT; increments each WAIT cycle without mem_done.
  - Reaching TIMEOUT sets mem_err (sticky until rst). FSM keeps waiting.
- Forwarding: exmem_alu_out / exmem_dst_reg / exmem_reg_write_en feed the execute stage's EX/MEM forwarding inputs. Load-use hazards are stalled upstream by the hazard unit, not here.
- Latency: EX to EX/MEM is 1 cycle; memory ops add 0..N WAIT cycles (0 when mem_done arrives in the first WAIT cycle).

Optional Feature:
- Macro EXMEM_PERF_CNT_EN.
- Defined: stall_cycles counts clk edges with stall_out=1. Saturates at 16'hFFFF; cleared by rst only.
- Undefined: no counter flops; stall_cycles tied to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, WAIT=1'b1), DATA_W/REG_W constants, bubble field values.
- One natural sub-module, exmem_mem_fsm: state register, mem_req/stall_out generation, timeout counter and mem_err.
- The field register stays flat in the top.

Test Plan:
- ADD with ex_alu_out=16'h1234, dst=3'd5, we=1, no mem -> next cycle exmem_alu_out=16'h1234, exmem_dst_reg=5, stall_out=0, mem_req=0.
- LD, mem_done delayed 3 cycles, mem_rdata=16'hBEEF -> mem_req=1 and stall_out=1 for 3 cycles; in the done cycle stall_out=0 and wb_data=16'hBEEF; FSM returns to IDLE; with EXMEM_PERF_CNT_EN, stall_cycles=3.
- ST then LD back-to-back, each with mem_done in its first WAIT cycle -> FSM stays WAIT, zero stall cycles, two mem_req cycles with addresses matching each op's ex_alu_out.
- flush=1 with a valid ST in EX while IDLE -> captured exmem_valid=0, mem_write=0, FSM stays IDLE; flush during WAIT -> access completes before the bubble is loaded.
- mem_done never arrives, TIMEOUT=8 -> mem_err=1 after 8 WAIT cycles and stays 1; mem_req still 1.
- rst asserted mid-WAIT -> mem_req, stall_out and all exmem_* fields go to 0 without a clock edge; FSM goes to IDLE.
